// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default widths and an address decoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package regfile_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 3;

   // Largest address width the decoder handles; callers cast the result down to their own DEPTH.
   localparam int MAX_ADDR_W = 8;
   localparam int MAX_DEPTH  = 2 ** MAX_ADDR_W;

   // Address -> one-hot register-select vector.
   function automatic logic [MAX_DEPTH-1:0] addr2onehot(input logic [MAX_ADDR_W-1:0] addr);
      logic [MAX_DEPTH-1:0] oh;
      oh       = '0;
      oh[addr] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending scoreboard: issue sets a register's bit, a write on either port clears it.
// Latency: set/clear take effect on the next rising edge; pending lookups are combinational.
// Backpressure: none; the hazard unit stalls on the reported pending bits.
// Ports: clock/reset; IssueEn/IssueReg mark a producer in flight; WE0/WR0, WE1/WR1 retire producers;
//        RReg1/RReg2 look up raw pending bits Pend1/Pend2 (no bypass or zero-register masking here).
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int ZERO_REG = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              IssueEn,
   input  logic [ADDR_W-1:0] IssueReg,
   input  logic              WE0,
   input  logic [ADDR_W-1:0] WR0,
   input  logic              WE1,
   input  logic [ADDR_W-1:0] WR1,
   input  logic [ADDR_W-1:0] RReg1,
   input  logic [ADDR_W-1:0] RReg2,
   output logic              Pend1,
   output logic              Pend2
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DEPTH-1:0] pending_q, pending_d;
   logic [DEPTH-1:0] set_vec, clr_vec;

   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (IssueEn) set_vec = DEPTH'(addr2onehot(MAX_ADDR_W'(IssueReg)));
      if (WE0)     clr_vec = clr_vec | DEPTH'(addr2onehot(MAX_ADDR_W'(WR0)));
      if (WE1)     clr_vec = clr_vec | DEPTH'(addr2onehot(MAX_ADDR_W'(WR1)));
      // Register 0 never has a producer in flight when it is hardwired.
      if (ZERO_REG != 0) set_vec[0] = 1'b0;
      // Set is applied after clear: a new producer issued on the retiring edge keeps the bit.
      pending_d = (pending_q & ~clr_vec) | set_vec;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) pending_q <= '0;
      else       pending_q <= pending_d;
   end

   assign Pend1 = pending_q[RReg1];
   assign Pend2 = pending_q[RReg2];

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: two async read ports, two clocked write ports, bypass, zero reg, scoreboard.
// Latency: reads and Busy/Hazard are combinational; writes and issues land on the rising edge.
// Backpressure: none; Hazard is the stall request for the pipeline's hazard unit.
// Ports: RReg1/RReg2 -> RRead1/RRead2 read data and Busy1/Busy2 pending flags, Hazard = Busy1|Busy2;
//        WE0/WR0/WD0 and WE1/WR1/WD1 write ports (port 1 wins on same address); IssueEn/IssueReg scoreboard.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] RReg1,
   input  logic [ADDR_W-1:0] RReg2,
   output logic [DATA_W-1:0] RRead1,
   output logic [DATA_W-1:0] RRead2,
   input  logic              WE0,
   input  logic [ADDR_W-1:0] WR0,
   input  logic [DATA_W-1:0] WD0,
   input  logic              WE1,
   input  logic [ADDR_W-1:0] WR1,
   input  logic [DATA_W-1:0] WD1,
   input  logic              IssueEn,
   input  logic [ADDR_W-1:0] IssueReg,
   output logic              Busy1,
   output logic              Busy2,
   output logic              Hazard
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic              wr0_ok, wr1_ok;
   logic [ADDR_W-1:0] raddr  [2];
   logic              pend   [2];

   // Writes to a hardwired register 0 are dropped before they reach the array.
   assign wr0_ok = WE0 && !((ZERO_REG != 0) && (WR0 == '0));
   assign wr1_ok = WE1 && !((ZERO_REG != 0) && (WR1 == '0));

   always_comb begin
      regs_d = regs_q;
      if (wr0_ok) regs_d[WR0] = WD0;
      // Port 1 is applied last so it overrides port 0 on an address collision.
      if (wr1_ok) regs_d[WR1] = WD1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) regs_q <= '{default: '0};
      else       regs_q <= regs_d;
   end

   regfile_scoreboard #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clock    (clock),
      .reset    (reset),
      .IssueEn  (IssueEn),
      .IssueReg (IssueReg),
      .WE0      (WE0),
      .WR0      (WR0),
      .WE1      (WE1),
      .WR1      (WR1),
      .RReg1    (RReg1),
      .RReg2    (RReg2),
      .Pend1    (pend[0]),
      .Pend2    (pend[1])
   );

   assign raddr[0] = RReg1;
   assign raddr[1] = RReg2;

   for (genvar k = 0; k < 2; k++) begin : g_rd
      logic              hit0, hit1, is_zero;
      logic [DATA_W-1:0] rd_val;
      logic              busy;

      always_comb begin
         is_zero = (ZERO_REG != 0) && (raddr[k] == '0);
         // Bypass is suppressed during reset so outputs read as the cleared array.
         hit0    = (BYPASS != 0) && !reset && WE0 && (WR0 == raddr[k]);
         hit1    = (BYPASS != 0) && !reset && WE1 && (WR1 == raddr[k]);
         rd_val  = regs_q[raddr[k]];
         if (hit0)    rd_val = WD0;
         if (hit1)    rd_val = WD1;
         if (is_zero) rd_val = '0;
         // A bypassed value is usable now, so the consumer need not wait for the retire edge.
         busy    = pend[k] && !hit0 && !hit1 && !is_zero;
      end
   end

   assign RRead1 = g_rd[0].rd_val;
   assign RRead2 = g_rd[1].rd_val;
   assign Busy1  = g_rd[0].busy;
   assign Busy2  = g_rd[1].busy;
   assign Hazard = Busy1 | Busy2;

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

   logic        clock = 1'b0;
   logic        reset;
   logic [2:0]  RReg1, RReg2, WR0, WR1, IssueReg;
   logic        WE0, WE1, IssueEn;
   logic [15:0] WD0, WD1;

   // Instance 0: ZERO_REG=1 BYPASS=1; instance 1: BYPASS=0; instance 2: ZERO_REG=0.
   logic [15:0] r1 [3];
   logic [15:0] r2 [3];
   logic        b1 [3];
   logic        b2 [3];
   logic        hz [3];

   int zero_c [3] = '{1, 1, 0};
   int byp_c  [3] = '{1, 0, 1};

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   logic [15:0] m_reg  [3][8];
   bit          m_pend [3][8];

   always #5 clock = ~clock;

   regfile_mp #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) u_dut (
      .clock(clock), .reset(reset), .RReg1(RReg1), .RReg2(RReg2), .RRead1(r1[0]), .RRead2(r2[0]),
      .WE0(WE0), .WR0(WR0), .WD0(WD0), .WE1(WE1), .WR1(WR1), .WD1(WD1),
      .IssueEn(IssueEn), .IssueReg(IssueReg), .Busy1(b1[0]), .Busy2(b2[0]), .Hazard(hz[0]));

   regfile_mp #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)) u_nobyp (
      .clock(clock), .reset(reset), .RReg1(RReg1), .RReg2(RReg2), .RRead1(r1[1]), .RRead2(r2[1]),
      .WE0(WE0), .WR0(WR0), .WD0(WD0), .WE1(WE1), .WR1(WR1), .WD1(WD1),
      .IssueEn(IssueEn), .IssueReg(IssueReg), .Busy1(b1[1]), .Busy2(b2[1]), .Hazard(hz[1]));

   regfile_mp #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) u_nozero (
      .clock(clock), .reset(reset), .RReg1(RReg1), .RReg2(RReg2), .RRead1(r1[2]), .RRead2(r2[2]),
      .WE0(WE0), .WR0(WR0), .WD0(WD0), .WE1(WE1), .WR1(WR1), .WD1(WD1),
      .IssueEn(IssueEn), .IssueReg(IssueReg), .Busy1(b1[2]), .Busy2(b2[2]), .Hazard(hz[2]));

   // ---------------- reference model ----------------
   task automatic model_clear();
      for (int c = 0; c < 3; c++)
         for (int a = 0; a < 8; a++) begin
            m_reg[c][a]  = '0;
            m_pend[c][a] = 1'b0;
         end
   endtask

   task automatic model_edge();
      for (int c = 0; c < 3; c++) begin
         if (WE0 && !(zero_c[c] != 0 && WR0 == 0)) m_reg[c][WR0] = WD0;
         if (WE1 && !(zero_c[c] != 0 && WR1 == 0)) m_reg[c][WR1] = WD1;
         if (WE0) m_pend[c][WR0] = 1'b0;
         if (WE1) m_pend[c][WR1] = 1'b0;
         if (IssueEn && !(zero_c[c] != 0 && IssueReg == 0)) m_pend[c][IssueReg] = 1'b1;
      end
   endtask

   function automatic logic [15:0] exp_read(int c, logic [2:0] a);
      if (reset) return 16'h0;
      if (zero_c[c] != 0 && a == 0) return 16'h0;
      if (byp_c[c] != 0 && WE1 && WR1 == a) return WD1;
      if (byp_c[c] != 0 && WE0 && WR0 == a) return WD0;
      return m_reg[c][a];
   endfunction

   function automatic logic exp_busy(int c, logic [2:0] a);
      if (reset) return 1'b0;
      if (zero_c[c] != 0 && a == 0) return 1'b0;
      if (byp_c[c] != 0 && ((WE0 && WR0 == a) || (WE1 && WR1 == a))) return 1'b0;
      return m_pend[c][a];
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic clk_edge();
      @(posedge clock);
      if (reset) model_clear();
      else       model_edge();
      #1;
   endtask

   task automatic set_reset(input logic v);
      reset = v;
      if (v) model_clear();
   endtask

   task automatic idle();
      WE0 = 1'b0; WE1 = 1'b0; IssueEn = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      idle();
      WR0 = 0; WR1 = 0; WD0 = 0; WD1 = 0; IssueReg = 0; RReg1 = 3; RReg2 = 5;
      set_reset(1'b1);
      #2;
      for (int c = 0; c < 3; c++) begin
         n_cmp++;
         if (r1[c] !== 16'h0 || r2[c] !== 16'h0 || b1[c] !== 1'b0 || b2[c] !== 1'b0 || hz[c] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state inst%0d: got rd=%h/%h busy=%b/%b hz=%b want all zero",
                     c, r1[c], r2[c], b1[c], b2[c], hz[c]);
         end
      end
      clk_edge();
      set_reset(1'b0);
   endtask

   task automatic test_seq_write_read();
      // Write, then reset mid-cycle: the value must vanish before the next edge.
      WE0 = 1; WR0 = 3; WD0 = 16'h7777;
      clk_edge();
      idle(); RReg1 = 3;
      #2;
      set_reset(1'b1);
      #1;
      n_cmp++;
      if (r1[0] !== 16'h0) begin
         n_bad++; $display("FAIL midrun_reset: got %h want 0000", r1[0]);
      end
      clk_edge();
      set_reset(1'b0);
      for (int i = 1; i < 8; i++) begin
         WE0 = 1; WR0 = 3'(i); WD0 = 16'(10 * (i + 1));
         clk_edge();
      end
      idle();
      for (int p = 0; p < 4; p++) begin
         RReg1 = 3'(2 * p + 1);
         RReg2 = 3'((2 * p + 2) % 8);
         #1;
         for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (r1[c] !== 16'(10 * (2 * p + 2)) || r2[c] !== ((p == 3) ? 16'd0 : 16'(10 * (2 * p + 3)))) begin
               n_bad++;
               $display("FAIL seq_pair%0d inst%0d: got %0d/%0d want %0d/%0d", p, c, r1[c], r2[c],
                        10 * (2 * p + 2), (p == 3) ? 0 : 10 * (2 * p + 3));
            end
         end
      end
      set_reset(1'b1);
      for (int p = 0; p < 4; p++) begin
         RReg1 = 3'(2 * p + 1);
         RReg2 = 3'(2 * p);
         #1;
         n_cmp++;
         if (r1[0] !== 16'h0 || r2[0] !== 16'h0) begin
            n_bad++; $display("FAIL reread_after_reset%0d: got %h/%h want 0000/0000", p, r1[0], r2[0]);
         end
      end
      clk_edge();
      set_reset(1'b0);
   endtask

   task automatic test_write_conflict();
      WE0 = 1; WR0 = 3; WD0 = 16'h1111;
      WE1 = 1; WR1 = 3; WD1 = 16'h2222;
      clk_edge();
      idle(); RReg1 = 3;
      #1;
      for (int c = 0; c < 3; c++) begin
         n_cmp++;
         if (r1[c] !== 16'h2222) begin
            n_bad++; $display("FAIL conflict_priority inst%0d: got %h want 2222", c, r1[c]);
         end
      end
      WE0 = 1; WR0 = 4; WD0 = 16'h4444;
      WE1 = 1; WR1 = 5; WD1 = 16'h5555;
      clk_edge();
      idle(); RReg1 = 4; RReg2 = 5;
      #1;
      n_cmp++;
      if (r1[0] !== 16'h4444 || r2[0] !== 16'h5555) begin
         n_bad++; $display("FAIL dual_write: got %h/%h want 4444/5555", r1[0], r2[0]);
      end
   endtask

   task automatic test_bypass();
      WE0 = 1; WR0 = 6; WD0 = 16'h1234;
      clk_edge();
      idle(); RReg1 = 6;
      WE0 = 1; WR0 = 6; WD0 = 16'hABCD;
      #1;
      n_cmp++;
      if (r1[0] !== 16'hABCD) begin
         n_bad++; $display("FAIL bypass_same_cycle: got %h want abcd", r1[0]);
      end
      n_cmp++;
      if (r1[1] !== 16'h1234) begin
         n_bad++; $display("FAIL nobypass_old_value: got %h want 1234", r1[1]);
      end
      clk_edge();
      idle();
      #1;
      n_cmp++;
      if (r1[1] !== 16'hABCD) begin
         n_bad++; $display("FAIL nobypass_after_edge: got %h want abcd", r1[1]);
      end
   endtask

   task automatic test_zero_reg();
      WE0 = 1; WR0 = 0; WD0 = 16'h5555;
      WE1 = 1; WR1 = 0; WD1 = 16'h5555;
      IssueEn = 1; IssueReg = 0; RReg1 = 0; RReg2 = 0;
      #1;
      n_cmp++;
      if (r1[0] !== 16'h0 || b1[0] !== 1'b0 || hz[0] !== 1'b0) begin
         n_bad++; $display("FAIL zero_during_write: got rd=%h busy=%b hz=%b want 0/0/0", r1[0], b1[0], hz[0]);
      end
      clk_edge();
      idle();
      #1;
      n_cmp++;
      if (r1[0] !== 16'h0 || r2[0] !== 16'h0 || b1[0] !== 1'b0 || hz[0] !== 1'b0) begin
         n_bad++; $display("FAIL zero_after_edge: got rd=%h/%h busy=%b hz=%b want 0", r1[0], r2[0], b1[0], hz[0]);
      end
      n_cmp++;
      if (r1[2] !== 16'h5555 || b1[2] !== 1'b1) begin
         n_bad++; $display("FAIL nozero_reg0: got rd=%h busy=%b want 5555/1", r1[2], b1[2]);
      end
   endtask

   task automatic test_scoreboard();
      idle(); IssueEn = 1; IssueReg = 2; RReg1 = 2; RReg2 = 1;
      clk_edge();
      idle();
      #1;
      n_cmp++;
      if (b1[0] !== 1'b1 || hz[0] !== 1'b1) begin
         n_bad++; $display("FAIL sb_issue: got busy=%b hz=%b want 1/1", b1[0], hz[0]);
      end
      WE1 = 1; WR1 = 2; WD1 = 16'h0202;
      #1;
      n_cmp++;
      if (b1[0] !== 1'b0 || b1[1] !== 1'b1) begin
         n_bad++; $display("FAIL sb_write_cycle: got byp=%b nobyp=%b want 0/1", b1[0], b1[1]);
      end
      clk_edge();
      idle();
      #1;
      n_cmp++;
      if (b1[0] !== 1'b0 || b1[1] !== 1'b0 || hz[0] !== 1'b0) begin
         n_bad++; $display("FAIL sb_retired: got busy=%b/%b hz=%b want 0/0/0", b1[0], b1[1], hz[0]);
      end
      IssueEn = 1; IssueReg = 2; WE0 = 1; WR0 = 2; WD0 = 16'h0303;
      clk_edge();
      idle();
      #1;
      n_cmp++;
      if (b1[0] !== 1'b1 || hz[0] !== 1'b1) begin
         n_bad++; $display("FAIL sb_set_wins: got busy=%b hz=%b want 1/1", b1[0], hz[0]);
      end
   endtask

   task automatic test_async_reset();
      WE0 = 1; WR0 = 5; WD0 = 16'h00FF;
      clk_edge();
      idle(); IssueEn = 1; IssueReg = 5;
      clk_edge();
      idle(); RReg1 = 5; RReg2 = 5;
      #1;
      n_cmp++;
      if (b1[0] !== 1'b1 || r1[0] !== 16'h00FF || hz[0] !== 1'b1) begin
         n_bad++; $display("FAIL areset_setup: got busy=%b rd=%h hz=%b want 1/00ff/1", b1[0], r1[0], hz[0]);
      end
      #2;
      set_reset(1'b1);
      IssueEn = 1; IssueReg = 5;
      #1;
      for (int c = 0; c < 3; c++) begin
         n_cmp++;
         if (b1[c] !== 1'b0 || b2[c] !== 1'b0 || hz[c] !== 1'b0 || r1[c] !== 16'h0) begin
            n_bad++; $display("FAIL areset_immediate inst%0d: got busy=%b hz=%b rd=%h want 0/0/0000",
                              c, b1[c], hz[c], r1[c]);
         end
      end
      clk_edge();
      set_reset(1'b0);
      idle();
      #1;
      n_cmp++;
      if (b1[0] !== 1'b0 || hz[0] !== 1'b0) begin
         n_bad++; $display("FAIL issue_during_reset: got busy=%b hz=%b want 0/0", b1[0], hz[0]);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 400; it++) begin
         WE0 = 1'($urandom_range(0, 1));  WR0 = 3'($urandom_range(0, 7)); WD0 = 16'($urandom());
         WE1 = 1'($urandom_range(0, 1));  WR1 = 3'($urandom_range(0, 7)); WD1 = 16'($urandom());
         IssueEn = 1'($urandom_range(0, 1)); IssueReg = 3'($urandom_range(0, 7));
         RReg1 = 3'($urandom_range(0, 7)); RReg2 = 3'($urandom_range(0, 7));
         set_reset(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0);
         #1;
         for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (r1[c] !== exp_read(c, RReg1) || r2[c] !== exp_read(c, RReg2)) begin
               n_bad++; $display("FAIL rand_read it%0d inst%0d: got %h/%h want %h/%h", it, c,
                                 r1[c], r2[c], exp_read(c, RReg1), exp_read(c, RReg2));
            end
            n_cmp++;
            if (b1[c] !== exp_busy(c, RReg1) || b2[c] !== exp_busy(c, RReg2) ||
                hz[c] !== (exp_busy(c, RReg1) | exp_busy(c, RReg2))) begin
               n_bad++; $display("FAIL rand_busy it%0d inst%0d: got %b%b hz=%b want %b%b", it, c,
                                 b1[c], b2[c], hz[c], exp_busy(c, RReg1), exp_busy(c, RReg2));
            end
         end
         clk_edge();
      end
      idle();
      set_reset(1'b0);
   endtask

   initial begin
      model_clear();
      test_reset();
      test_seq_write_read();
      test_write_conflict();
      test_bypass();
      test_zero_reg();
      test_scoreboard();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
